piso_serializer: RTL and testbench



---
 rtl/piso_serializer.sv | 107 ++++++++++
 tb/tb_piso_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out loader feeding the serial shift chain
//
// Purpose: accepts a WIDTH-bit word over a valid/ready handshake and shifts it
// out one bit per clock, flagging payload bits and the final bit of each word.
// Back-to-back words stream with no idle gap.
//
// Ports:
//   clk          in   rising-edge clock, shared with the downstream chain
//   rst_n        in   asynchronous active-low reset
//   in_data      in   parallel word, sampled only on a handshake edge
//   in_valid     in   upstream has a word on in_data
//   in_ready     out  block can accept a word this cycle
//   serial_out   out  serial bit, drives the shift chain d input
//   serial_valid out  serial_out carries a payload bit this cycle
//   last_bit     out  serial_out carries the final bit of the current word
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             last_bit
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic xfer;
  logic cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Ready depends only on registered state so the handshake never forms a
  // combinational loop with the upstream valid.
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_SHIFT) && cnt_zero);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          shreg_d = in_data;
          cnt_d   = CNT_LOAD;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!cnt_zero) begin
          // Move the next bit toward the output end, zero-filling behind it.
          if (LSB_FIRST) begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          end else begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - 1'b1;
        end else if (xfer) begin
          // Reload on the last bit so the next word follows with no gap.
          shreg_d = in_data;
          cnt_d   = CNT_LOAD;
        end else begin
          shreg_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        shreg_d = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode registers only; gating with state keeps them low in IDLE.
  assign serial_valid = (state_q == S_SHIFT);
  assign serial_out   = serial_valid && (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1]);
  assign last_bit     = serial_valid && cnt_zero;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;

  logic       clk;
  logic       rst_n;

  logic [7:0] a_in_data;
  logic       a_in_valid;
  logic       a_in_ready, a_serial_out, a_serial_valid, a_last_bit;

  logic [7:0] b_in_data;
  logic       b_in_valid;
  logic       b_in_ready, b_serial_out, b_serial_valid, b_last_bit;

  logic [3:0] chain_q;

  int n_tests;
  int n_fail;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (a_in_data),
    .in_valid     (a_in_valid),
    .in_ready     (a_in_ready),
    .serial_out   (a_serial_out),
    .serial_valid (a_serial_valid),
    .last_bit     (a_last_bit)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (b_in_data),
    .in_valid     (b_in_valid),
    .in_ready     (b_in_ready),
    .serial_out   (b_serial_out),
    .serial_valid (b_serial_valid),
    .last_bit     (b_last_bit)
  );

  // Stand-in for the downstream 4-stage serial shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= '0;
    else        chain_q <= {chain_q[2:0], a_serial_out};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the MSB-first instance shows its first payload bit.
  task automatic wait_a_valid(input string tag);
    for (int i = 0; i < 4; i++) begin
      if (a_serial_valid) break;
      step();
    end
    chk(tag, {31'd0, a_serial_valid}, 32'd1);
  endtask

  task automatic wait_b_valid(input string tag);
    for (int i = 0; i < 4; i++) begin
      if (b_serial_valid) break;
      step();
    end
    chk(tag, {31'd0, b_serial_valid}, 32'd1);
  endtask

  logic [15:0] exp_stream;
  logic [7:0]  exp_word;
  logic        hist[$];

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    a_in_data  = '0;
    a_in_valid = 1'b0;
    b_in_data  = '0;
    b_in_valid = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_ready", {31'd0, a_in_ready}, 32'd1);
    chk("rst_valid", {31'd0, a_serial_valid}, 32'd0);
    chk("rst_sout",  {31'd0, a_serial_out}, 32'd0);
    chk("rst_last",  {31'd0, a_last_bit}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", {31'd0, a_in_ready}, 32'd1);

    // Single word MSB-first: 0xA5 -> 1,0,1,0,0,1,0,1
    exp_word   = 8'hA5;
    a_in_data  = 8'hA5;
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    a_in_data  = 8'h00;
    wait_a_valid("single_start");
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("single_bit%0d", k), {31'd0, a_serial_out}, {31'd0, exp_word[7-k]});
      chk($sformatf("single_val%0d", k), {31'd0, a_serial_valid}, 32'd1);
      chk($sformatf("single_last%0d", k), {31'd0, a_last_bit}, (k == 7) ? 32'd1 : 32'd0);
      step();
    end
    chk("single_end_sout",  {31'd0, a_serial_out}, 32'd0);
    chk("single_end_valid", {31'd0, a_serial_valid}, 32'd0);
    chk("single_end_ready", {31'd0, a_in_ready}, 32'd1);
    step();

    // Back-to-back: 0xA5 then 0x3C with in_valid held
    exp_stream = 16'hA53C;
    a_in_data  = 8'hA5;
    a_in_valid = 1'b1;
    step();
    wait_a_valid("b2b_start");
    for (int k = 0; k < 16; k++) begin
      if (k == 8) a_in_valid = 1'b0;
      chk($sformatf("b2b_bit%0d", k), {31'd0, a_serial_out}, {31'd0, exp_stream[15-k]});
      chk($sformatf("b2b_val%0d", k), {31'd0, a_serial_valid}, 32'd1);
      chk($sformatf("b2b_last%0d", k), {31'd0, a_last_bit}, (k == 7 || k == 15) ? 32'd1 : 32'd0);
      if (k == 7) begin
        chk("b2b_ready_last", {31'd0, a_in_ready}, 32'd1);
        a_in_data = 8'h3C;
      end
      step();
    end
    chk("b2b_end_valid", {31'd0, a_serial_valid}, 32'd0);
    step();

    // LSB-first: 0x01 -> 1 then seven 0s
    b_in_data  = 8'h01;
    b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    b_in_data  = 8'h00;
    wait_b_valid("lsb_start");
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("lsb_bit%0d", k), {31'd0, b_serial_out}, (k == 0) ? 32'd1 : 32'd0);
      chk($sformatf("lsb_last%0d", k), {31'd0, b_last_bit}, (k == 7) ? 32'd1 : 32'd0);
      step();
    end
    chk("lsb_end_valid", {31'd0, b_serial_valid}, 32'd0);
    step();

    // Busy rejection: 0xFF offered during bits 2..6 of an in-flight 0x00
    a_in_data  = 8'h00;
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    wait_a_valid("busy_start");
    for (int k = 1; k <= 8; k++) begin
      if (k >= 2 && k <= 6) begin
        a_in_data  = 8'hFF;
        a_in_valid = 1'b1;
        chk($sformatf("busy_ready%0d", k), {31'd0, a_in_ready}, 32'd0);
      end else begin
        a_in_valid = 1'b0;
        a_in_data  = 8'h00;
      end
      chk($sformatf("busy_bit%0d", k), {31'd0, a_serial_out}, 32'd0);
      chk($sformatf("busy_val%0d", k), {31'd0, a_serial_valid}, 32'd1);
      step();
    end
    chk("busy_end_valid", {31'd0, a_serial_valid}, 32'd0);
    step();

    // Reset mid-word after 3 bits of 0xFF
    a_in_data  = 8'hFF;
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    a_in_data  = 8'h00;
    wait_a_valid("rstmid_start");
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rstmid_bit%0d", k), {31'd0, a_serial_out}, 32'd1);
      if (k < 2) step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_sout",  {31'd0, a_serial_out}, 32'd0);
    chk("rstmid_valid", {31'd0, a_serial_valid}, 32'd0);
    chk("rstmid_last",  {31'd0, a_last_bit}, 32'd0);
    chk("rstmid_ready", {31'd0, a_in_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("rstmid_quiet%0d", k), {31'd0, a_serial_valid}, 32'd0);
    end

    // Chain integration: 0xC3, chain output lags serial_out by exactly 4 cycles
    exp_word   = 8'hC3;
    a_in_data  = 8'hC3;
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    a_in_data  = 8'h00;
    wait_a_valid("chain_start");
    hist.delete();
    for (int t = 0; t < 12; t++) begin
      if (t < 8) chk($sformatf("chain_src%0d", t), {31'd0, a_serial_out}, {31'd0, exp_word[7-t]});
      hist.push_back(a_serial_out);
      if (t >= 4) chk($sformatf("chain_out%0d", t - 4), {31'd0, chain_q[3]}, {31'd0, exp_word[7-(t-4)]});
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
